freelist: RTL and testbench

- Physical-register free list for the 4-wide rename stage, fed directly by the reorder buffer's commit outputs.
- Returns committed physical tags: the old prd for a valid commit, the new prd for a killed entry.
- Hands up to 4 free tags per cycle to rename.
- Circular FIFO of register tags, with all-or-nothing allocation and compacted push/pop.

---
 rtl/freelist_pkg.sv | 21 ++
 rtl/prefix_cnt4.sv | 18 +
 rtl/freelist.sv | 127 ++++++++++++
 tb/tb_freelist.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_pkg.sv
// Shared rename/commit constants, the physical tag type and the 4-lane tag packing
// used on both the free-list alloc bus and the reorder-buffer commit bus.
package freelist_pkg;

  localparam int unsigned NBANK     = 4;
  localparam int unsigned WIDTH_REG = 7;
  localparam int unsigned NARCH     = 32;
  localparam int unsigned NPREG     = 1 << WIDTH_REG;
  localparam int unsigned CNT_W     = WIDTH_REG + 1;
  localparam int unsigned LANE_W    = 3;

  typedef logic [WIDTH_REG-1:0] prd_t;
  typedef prd_t [NBANK-1:0]     prd4x_t;
  typedef logic [LANE_W-1:0]    lane_cnt_t;

  // Lane k occupies bits [(k+1)*WIDTH_REG-1 : k*WIDTH_REG] of a packed 4-lane bus.
  function automatic prd_t get_lane(input prd4x_t v, input int unsigned k);
    return v[k[1:0]];
  endfunction

endpackage

// File: rtl/prefix_cnt4.sv
// Exclusive per-lane prefix population counts of a 4-bit strobe vector, plus its total.
module prefix_cnt4
  import freelist_pkg::*;
(
  input  logic [NBANK-1:0]      vec,
  output lane_cnt_t [NBANK-1:0] pre_c,
  output lane_cnt_t             total_c
);

  always_comb begin
    pre_c[0] = '0;
    for (int k = 1; k < NBANK; k++) begin
      pre_c[k] = pre_c[k-1] + LANE_W'(vec[k-1]);
    end
    total_c = pre_c[NBANK-1] + LANE_W'(vec[NBANK-1]);
  end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular FIFO of tags, 4-wide compacted alloc/free.
// Optional double-free detection with a free bitmap under FREELIST_DFREE_CHECK_EN.
module freelist
  import freelist_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NBANK-1:0]           i_alloc_req,
  input  logic                       i_alloc_we,
  output logic                       o_alloc_ok,
  output logic [NBANK*WIDTH_REG-1:0] o_alloc_prd4x,
  input  logic [NBANK-1:0]           i_free_en,
  input  logic [NBANK*WIDTH_REG-1:0] i_free_prd4x,
  output logic [CNT_W-1:0]           o_count,
  output logic                       o_err
);

  prd_t                 q [NPREG];
  prd_t                 head;
  prd_t                 tail;
  logic [CNT_W-1:0]     count;
  lane_cnt_t [NBANK-1:0] a_pre;
  lane_cnt_t [NBANK-1:0] f_pre;
  lane_cnt_t            a_tot;
  lane_cnt_t            f_tot;
  lane_cnt_t            npop;
  logic [NBANK-1:0]     free_v;
  prd4x_t               free_tags;
  prd4x_t               alloc_lanes;
  logic                 ovf;
  logic                 push_ok;
  logic                 dfree_err;

  assign free_tags = i_free_prd4x;

  prefix_cnt4 u_alloc_cnt (.vec(i_alloc_req), .pre_c(a_pre), .total_c(a_tot));
  prefix_cnt4 u_free_cnt  (.vec(free_v),      .pre_c(f_pre), .total_c(f_tot));

  // Requesting lanes read consecutive entries from head; idle lanes drive 0.
  always_comb begin
    alloc_lanes = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (i_alloc_req[k]) begin
        alloc_lanes[k] = q[head + WIDTH_REG'(a_pre[k])];
      end
    end
  end

  assign o_alloc_ok    = count >= CNT_W'(a_tot);
  assign o_alloc_prd4x = alloc_lanes;
  assign o_count       = count;
  assign npop          = (i_alloc_we && o_alloc_ok) ? a_tot : '0;

  // More free tags than physical registers means a tag was returned twice.
  assign ovf     = (count + CNT_W'(f_tot)) > CNT_W'(NPREG);
  assign push_ok = !ovf;

`ifdef FREELIST_DFREE_CHECK_EN
  logic [NPREG-1:0] fmap;
  logic [NPREG-1:0] fmap_next;
  logic [NBANK-1:0] dup;

  // Drop a lane whose tag is already free, is tag 0, or repeats an earlier lane's tag.
  always_comb begin
    dup = '0;
    for (int k = 1; k < NBANK; k++) begin
      for (int j = 0; j < k; j++) begin
        if (i_free_en[j] && i_free_en[k] && (free_tags[j] == free_tags[k])) begin
          dup[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NBANK; k++) begin
      free_v[k] = i_free_en[k] && !dup[k] && !fmap[free_tags[k]] && (free_tags[k] != '0);
    end
    dfree_err = |(i_free_en & ~free_v);
  end

  always_comb begin
    fmap_next = fmap;
    if (i_alloc_we && o_alloc_ok) begin
      for (int k = 0; k < NBANK; k++) begin
        if (i_alloc_req[k]) fmap_next[alloc_lanes[k]] = 1'b0;
      end
    end
    if (push_ok) begin
      for (int k = 0; k < NBANK; k++) begin
        if (free_v[k]) fmap_next[free_tags[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fmap <= {{(NPREG-NARCH){1'b1}}, {NARCH{1'b0}}};
    end else begin
      fmap <= fmap_next;
    end
  end
`else
  assign free_v    = i_free_en;
  assign dfree_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NPREG; i++) begin
        q[i] <= (i < NPREG - NARCH) ? WIDTH_REG'(NARCH + i) : '0;
      end
      head  <= '0;
      tail  <= WIDTH_REG'(NPREG - NARCH);
      count <= CNT_W'(NPREG - NARCH);
      o_err <= 1'b0;
    end else begin
      head <= head + WIDTH_REG'(npop);
      if (push_ok) begin
        for (int k = 0; k < NBANK; k++) begin
          if (free_v[k]) q[tail + WIDTH_REG'(f_pre[k])] <= free_tags[k];
        end
        tail <= tail + WIDTH_REG'(f_tot);
      end
      count <= count - CNT_W'(npop) + (push_ok ? CNT_W'(f_tot) : CNT_W'(0));
      o_err <= o_err | ovf | dfree_err;
    end
  end

endmodule

// File: tb/tb_freelist.sv
// Directed self-checking bench for the free list: reset, compaction, boundaries,
// simultaneous push/pop, pointer wrap, overflow or double-free.
module tb_freelist;
  import freelist_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NBANK-1:0]           alloc_req;
  logic                       alloc_we;
  logic                       alloc_ok;
  logic [NBANK*WIDTH_REG-1:0] alloc_prd4x;
  logic [NBANK-1:0]           free_en;
  logic [NBANK*WIDTH_REG-1:0] free_prd4x;
  logic [WIDTH_REG:0]         count;
  logic                       err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  freelist dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_alloc_req   (alloc_req),
    .i_alloc_we    (alloc_we),
    .o_alloc_ok    (alloc_ok),
    .o_alloc_prd4x (alloc_prd4x),
    .i_free_en     (free_en),
    .i_free_prd4x  (free_prd4x),
    .o_count       (count),
    .o_err         (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int unsigned k);
    return 32'(get_lane(alloc_prd4x, k));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req  = '0;
    alloc_we   = 1'b0;
    free_en    = '0;
    free_prd4x = '0;
  endtask

  // Reset is asserted asynchronously, whatever the inputs are doing.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_count", 32'(count), 32'd96);
    check_eq("rst_err", 32'(err), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_free(input logic [3:0] en, input int t0, input int t1, input int t2,
                          input int t3);
    free_en    = en;
    free_prd4x = {WIDTH_REG'(t3), WIDTH_REG'(t2), WIDTH_REG'(t1), WIDTH_REG'(t0)};
  endtask

  logic [3:0] req_pat  [5] = '{4'b1111, 4'b1010, 4'b0111, 4'b0001, 4'b1101};
  logic [3:0] free_pat [5] = '{4'b0000, 4'b0100, 4'b1001, 4'b1011, 4'b1111};

  initial begin
    int mq[$];
    int prev[$];
    int nxt[$];
    int j;
    logic [3:0] rq;
    logic [3:0] fm;

    idle();
    rst_n = 1'b1;
    #2;
    do_reset();

    // Full-width grant straight out of reset
    alloc_req = 4'b1111;
    alloc_we  = 1'b1;
    #1;
    check_eq("t1_ok", 32'(alloc_ok), 32'd1);
    check_eq("t1_l0", lane(0), 32'd32);
    check_eq("t1_l1", lane(1), 32'd33);
    check_eq("t1_l2", lane(2), 32'd34);
    check_eq("t1_l3", lane(3), 32'd35);
    tick();
    idle();
    check_eq("t1_count", 32'(count), 32'd92);

    // Gap compaction
    do_reset();
    alloc_req = 4'b1010;
    alloc_we  = 1'b1;
    #1;
    check_eq("t2_l0", lane(0), 32'd0);
    check_eq("t2_l1", lane(1), 32'd32);
    check_eq("t2_l2", lane(2), 32'd0);
    check_eq("t2_l3", lane(3), 32'd33);
    tick();
    check_eq("t2_count", 32'(count), 32'd94);
    alloc_req = 4'b0001;
    #1;
    check_eq("t2_next_l0", lane(0), 32'd34);
    tick();
    idle();

    // Drain to 2, refuse a 3-lane request, then push and pop in the same cycle
    do_reset();
    alloc_req = 4'b1111;
    alloc_we  = 1'b1;
    repeat (23) tick();
    alloc_req = 4'b0011;
    tick();
    check_eq("t3_count2", 32'(count), 32'd2);
    alloc_req = 4'b0111;
    #1;
    check_eq("t3_ok_short", 32'(alloc_ok), 32'd0);
    tick();
    check_eq("t3_count_hold", 32'(count), 32'd2);
    set_free(4'b0101, 7, 0, 5, 0);
    #1;
    check_eq("t4_no_bypass", 32'(alloc_ok), 32'd0);
    alloc_req = 4'b0011;
    #1;
    check_eq("t4_ok", 32'(alloc_ok), 32'd1);
    check_eq("t4_l0", lane(0), 32'd126);
    check_eq("t4_l1", lane(1), 32'd127);
    tick();
    idle();
    check_eq("t4_count", 32'(count), 32'd2);
    alloc_req = 4'b0011;
    alloc_we  = 1'b1;
    #1;
    check_eq("t4_freed_l0", lane(0), 32'd7);
    check_eq("t4_freed_l1", lane(1), 32'd5);
    tick();
    check_eq("t4_count0", 32'(count), 32'd0);
    alloc_req = 4'b0001;
    #1;
    check_eq("t4_empty_ok", 32'(alloc_ok), 32'd0);
    alloc_req = 4'b0000;
    #1;
    check_eq("t4_noreq_ok", 32'(alloc_ok), 32'd1);
    tick();
    idle();
    check_eq("t4_count_stay", 32'(count), 32'd0);

    // Pointer wrap: tags granted one cycle are freed the next, FIFO order tracked
    do_reset();
    mq.delete();
    prev.delete();
    for (int t = int'(NARCH); t < int'(NPREG); t++) mq.push_back(t);
    for (int i = 0; i < 120; i++) begin
      rq = req_pat[i % 5];
      fm = free_pat[prev.size()];
      free_en    = fm;
      free_prd4x = '0;
      j = 0;
      for (int k = 0; k < 4; k++) begin
        if (fm[k]) begin
          free_prd4x[k*WIDTH_REG +: WIDTH_REG] = WIDTH_REG'(prev[j]);
          j++;
        end
      end
      alloc_req = rq;
      alloc_we  = 1'b1;
      #1;
      check_eq("wrap_ok", 32'(alloc_ok), 32'd1);
      nxt.delete();
      j = 0;
      for (int k = 0; k < 4; k++) begin
        if (rq[k]) begin
          check_eq("wrap_lane", lane(k), 32'(mq[j]));
          nxt.push_back(mq[j]);
          j++;
        end else begin
          check_eq("wrap_idle", lane(k), 32'd0);
        end
      end
      tick();
      for (int k = 0; k < nxt.size(); k++) void'(mq.pop_front());
      foreach (prev[p]) mq.push_back(prev[p]);
      prev = nxt;
      check_eq("wrap_count", 32'(count), 32'(mq.size()));
    end
    idle();

`ifdef FREELIST_DFREE_CHECK_EN
    // Freeing a tag that is already free
    do_reset();
    set_free(4'b0010, 0, 40, 0, 0);
    tick();
    idle();
    check_eq("df_err", 32'(err), 32'd1);
    check_eq("df_count", 32'(count), 32'd96);
    tick();
    check_eq("df_sticky", 32'(err), 32'd1);
    // Two lanes freeing the same tag: only the first is kept
    do_reset();
    set_free(4'b0011, 10, 10, 0, 0);
    tick();
    idle();
    check_eq("dup_count", 32'(count), 32'd97);
    check_eq("dup_err", 32'(err), 32'd1);
`else
    // Returning more tags than exist trips the overflow guard
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_free(4'b1111, 4*c, 4*c + 1, 4*c + 2, 4*c + 3);
      tick();
    end
    idle();
    check_eq("ovf_full", 32'(count), 32'd128);
    check_eq("ovf_err0", 32'(err), 32'd0);
    set_free(4'b0001, 100, 0, 0, 0);
    tick();
    idle();
    check_eq("ovf_err", 32'(err), 32'd1);
    check_eq("ovf_count", 32'(count), 32'd128);
    alloc_req = 4'b1111;
    alloc_we  = 1'b1;
    #1;
    check_eq("ovf_l0", lane(0), 32'd32);
    check_eq("ovf_l3", lane(3), 32'd35);
    tick();
    idle();
    check_eq("ovf_count_after", 32'(count), 32'd124);
    check_eq("ovf_sticky", 32'(err), 32'd1);
`endif

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
